entrada_condicionador: RTL and testbench

Input conditioning stage upstream of the BullsCows game block on the Nexys A7. Synchronises the 16 slide switches and the `ssl` (confirm) push-button to `clock` and debounces them. Delivers a stable switch word and a single-cycle confirm pulse, so the game FSM never sees metastable values, bounce or repeated presses. Instantiated in the top level between the board pins and the game's `SW`/`ssl` inputs.

---
 rtl/bc_pkg.sv | 9 +
 rtl/debounce_btn.sv | 107 ++++++++++
 rtl/entrada_condicionador.sv | 66 ++++++
 tb/tb_entrada_condicionador.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bc_pkg.sv
// Shared types and board constants for the BullsCows input path.
package bc_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} btn_state_t;

  localparam int CLK_HZ = 100_000_000;
  localparam int DEB_MS = 10;

endpackage

// File: rtl/debounce_btn.sv
// Single push-button conditioner: 2-flop synchroniser, press/release
// debounce FSM, one-cycle press pulse and level output.
// Optional macro ENTRADA_LONGPRESS_EN adds a one-cycle long-press pulse.
import bc_pkg::*;

module debounce_btn #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int CNT_W      = $clog2(DEB_CYCLES)
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_pulse,
  output logic btn_level,
  output logic btn_long
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             btn_s1, btn_s;
  btn_state_t       state, state_nxt;
  logic [CNT_W-1:0] btn_cnt, cnt_nxt;
  logic             pulse_nxt;

  // Two-flop synchroniser; nothing downstream looks at btn_raw.
  always_ff @(posedge clock) begin
    if (!reset) begin
      btn_s1 <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s  <= btn_s1;
    end
  end

  // State, debounce counter and registered pulse.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      btn_cnt   <= '0;
      btn_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      btn_cnt   <= cnt_nxt;
      btn_pulse <= pulse_nxt;
    end
  end

  // Next state: a level must hold DEB_CYCLES cycles in the check states.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = btn_cnt;
    pulse_nxt = 1'b0;
    case (state)
      IDLE:
        if (btn_s) begin
          state_nxt = PRESS_CHK;
          cnt_nxt   = '0;
        end
      PRESS_CHK:
        if (!btn_s)                  state_nxt = IDLE;
        else if (btn_cnt == CNT_MAX) begin
          state_nxt = HELD;
          pulse_nxt = 1'b1;
        end else                     cnt_nxt = btn_cnt + 1'b1;
      HELD:
        if (!btn_s) begin
          state_nxt = REL_CHK;
          cnt_nxt   = '0;
        end
      REL_CHK:
        if (btn_s)                   state_nxt = HELD;
        else if (btn_cnt == CNT_MAX) state_nxt = IDLE;
        else                         cnt_nxt = btn_cnt + 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  assign btn_level = (state == HELD) || (state == REL_CHK);

`ifdef ENTRADA_LONGPRESS_EN
  localparam int             LP_MAX = 200 * DEB_CYCLES;
  localparam int             LP_W   = $clog2(LP_MAX + 1);
  localparam logic [LP_W-1:0] LP_TOP = LP_W'(LP_MAX);

  logic [LP_W-1:0] lp_cnt;

  // Hold-time counter; saturates so the long pulse fires only once per hold.
  always_ff @(posedge clock) begin
    if (!reset) begin
      lp_cnt   <= '0;
      btn_long <= 1'b0;
    end else begin
      btn_long <= 1'b0;
      if (!btn_level) begin
        lp_cnt <= '0;
      end else if (lp_cnt != LP_TOP) begin
        lp_cnt   <= lp_cnt + 1'b1;
        btn_long <= (lp_cnt == LP_TOP - 1'b1);
      end
    end
  end
`else
  assign btn_long = 1'b0;
`endif

endmodule

// File: rtl/entrada_condicionador.sv
// Input conditioner between board pins and the BullsCows game block:
// synchronised, debounced switch word plus confirm-button pulse/level.
// Optional macro ENTRADA_LONGPRESS_EN enables the ssl_long output.
import bc_pkg::*;

module entrada_condicionador #(
  parameter int SW_WIDTH   = 16,
  parameter int DEB_CYCLES = CLK_HZ / 1000 * DEB_MS,
  parameter int CNT_W      = $clog2(DEB_CYCLES)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [SW_WIDTH-1:0] sw_raw,
  input  logic                ssl_raw,
  output logic [SW_WIDTH-1:0] sw_clean,
  output logic                ssl_pulse,
  output logic                ssl_level,
  output logic                ssl_long
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [SW_WIDTH-1:0] sw_s1, sw_s, sw_cand;
  logic [CNT_W-1:0]    sw_cnt;

  // Two-flop synchroniser for the whole switch word.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sw_s1 <= '0;
      sw_s  <= '0;
    end else begin
      sw_s1 <= sw_raw;
      sw_s  <= sw_s1;
    end
  end

  // Word-wide debounce: any bit change restarts the window, so sw_clean
  // only ever moves to a complete, stable word.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sw_cand  <= '0;
      sw_cnt   <= '0;
      sw_clean <= '0;
    end else if (sw_s != sw_cand) begin
      sw_cand <= sw_s;
      sw_cnt  <= '0;
    end else if (sw_cnt == CNT_MAX) begin
      sw_clean <= sw_cand;
    end else begin
      sw_cnt <= sw_cnt + 1'b1;
    end
  end

  debounce_btn #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_ssl (
    .clock     (clock),
    .reset     (reset),
    .btn_raw   (ssl_raw),
    .btn_pulse (ssl_pulse),
    .btn_level (ssl_level),
    .btn_long  (ssl_long)
  );

endmodule

// File: tb/tb_entrada_condicionador.sv
// Scoreboard bench for entrada_condicionador with DEB_CYCLES = 4.
// Expected pulse / switch-word events are queued with their cycle when
// stimulus is driven; negedge monitors pop and compare as outputs move.
module tb_entrada_condicionador;

  localparam int LAT = 7;  // 2 sync + 4 debounce + 1 register

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] sw_raw;
  logic        ssl_raw;
  logic [15:0] sw_clean;
  logic        ssl_pulse, ssl_level, ssl_long;

  typedef struct {int cyc; logic [15:0] val;} sw_ev_t;

  int     cyc = 0;
  int     n_tests = 0;
  int     n_fail = 0;
  bit     mon_en = 1'b0;
  int     pulse_q[$];
  int     long_q[$];
  sw_ev_t sw_q[$];
  logic [15:0] sw_prev = '0;

  entrada_condicionador #(.SW_WIDTH(16), .DEB_CYCLES(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .sw_raw    (sw_raw),
    .ssl_raw   (ssl_raw),
    .sw_clean  (sw_clean),
    .ssl_pulse (ssl_pulse),
    .ssl_level (ssl_level),
    .ssl_long  (ssl_long)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic set_sw(input logic [15:0] v, input bit commits);
    sw_raw = v;
    if (commits) sw_q.push_back('{cyc + LAT, v});
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_sw"},    32'(sw_clean),  32'h0);
    chk({tag, "_pulse"}, 32'(ssl_pulse), 32'h0);
    chk({tag, "_level"}, 32'(ssl_level), 32'h0);
    chk({tag, "_long"},  32'(ssl_long),  32'h0);
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_pulse_q"}, 32'(pulse_q.size()), 32'h0);
    chk({tag, "_sw_q"},    32'(sw_q.size()),    32'h0);
    chk({tag, "_long_q"},  32'(long_q.size()),  32'h0);
  endtask

  // Press-pulse monitor.
  always @(negedge clock) begin
    if (mon_en && ssl_pulse) begin
      if (pulse_q.size() == 0) chk("pulse_unexpected", 32'd1, 32'd0);
      else begin
        chk("pulse_cyc", 32'(cyc), 32'(pulse_q[0]));
        pulse_q.delete(0);
      end
    end
  end

  // Long-press monitor.
  always @(negedge clock) begin
    if (mon_en && ssl_long) begin
      if (long_q.size() == 0) chk("long_unexpected", 32'd1, 32'd0);
      else begin
        chk("long_cyc", 32'(cyc), 32'(long_q[0]));
        long_q.delete(0);
      end
    end
  end

  // Switch-word monitor: every change must match a queued event exactly.
  always @(negedge clock) begin
    if (mon_en && sw_clean !== sw_prev) begin
      if (sw_q.size() == 0) chk("sw_unexpected", 32'(sw_clean), 32'(sw_prev));
      else begin
        chk("sw_cyc", 32'(cyc), 32'(sw_q[0].cyc));
        chk("sw_val", 32'(sw_clean), 32'(sw_q[0].val));
        sw_q.delete(0);
      end
    end
    sw_prev <= sw_clean;
  end

  initial begin
    int m;
    reset   = 1'b0;
    sw_raw  = 16'h00A5;
    ssl_raw = 1'b0;
    tick(3);
    chk_idle_outputs("reset");
    mon_en = 1'b1;

    // Reset release with a static switch word.
    reset = 1'b1;
    sw_q.push_back('{cyc + LAT, 16'h00A5});
    tick(12);
    chk("sw_after_reset", 32'(sw_clean), 32'h00A5);
    chk_drained("t1");

    // Clean 20-cycle press: level tracks the debounced state.
    ssl_raw = 1'b1;
    pulse_q.push_back(cyc + LAT);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == LAT - 1) chk("level_pre_rise", 32'(ssl_level), 32'h0);
      if (i == LAT)     chk("level_rise",     32'(ssl_level), 32'h1);
    end
    ssl_raw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == LAT - 1) chk("level_pre_fall", 32'(ssl_level), 32'h1);
      if (i == LAT)     chk("level_fall",     32'(ssl_level), 32'h0);
    end
    chk_drained("t2");

    // Bounce every cycle: never accepted.
    for (int i = 0; i < 10; i++) begin
      ssl_raw = (i % 2 == 0);
      tick();
    end
    ssl_raw = 1'b0;
    tick(10);
    chk("bounce_level", 32'(ssl_level), 32'h0);
    chk_drained("t3");

    // Press, release glitch, and a switch change while held.
    set_sw(16'h0001, 1'b1);
    tick(10);
    ssl_raw = 1'b1;
    pulse_q.push_back(cyc + LAT);
    tick(12);
    ssl_raw = 1'b0;
    tick(2);
    ssl_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("glitch_level", 32'(ssl_level), 32'h1);
    end
    set_sw(16'h0003, 1'b1);
    tick(10);
    chk("sw_during_hold", 32'(sw_clean), 32'h0003);
    ssl_raw = 1'b0;
    tick(10);
    chk_drained("t4");

    // Switch bit 3 chatter never commits; final word lands atomically.
    for (int i = 0; i < 5; i++) begin
      set_sw(sw_raw ^ 16'h0008, 1'b0);
      tick(3);
    end
    chk("sw_chatter_hold", 32'(sw_clean), 32'h0003);
    set_sw(16'h5A5B, 1'b1);
    tick(10);
    chk_drained("t5");

    // Reset during PRESS_CHK discards the press.
    ssl_raw = 1'b1;
    tick(5);
    reset   = 1'b0;
    ssl_raw = 1'b0;
    sw_raw  = 16'h0000;
    sw_q.push_back('{cyc + 1, 16'h0000});
    tick();
    chk_idle_outputs("mid_reset");
    reset = 1'b1;
    tick(12);
    chk_idle_outputs("post_reset");
    chk_drained("t6");

    // Long hold: one press pulse, long pulse only with the feature built in.
    ssl_raw = 1'b1;
    m = cyc;
    pulse_q.push_back(m + LAT);
`ifdef ENTRADA_LONGPRESS_EN
    long_q.push_back(m + LAT + 800);
`endif
    tick(830);
    chk("long_hold_level", 32'(ssl_level), 32'h1);
    ssl_raw = 1'b0;
    tick(12);
    chk_drained("t7");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
